// File: rtl/soc_eeg_streamer_pkg.sv
// Shared types for the EEG sample streamer.
package soc_eeg_streamer_pkg;

    typedef logic [15:0] AdcData_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_START,
        STREAM,
        EPOCH,
        WAIT_INF,
        DONE
    } state_t;

endpackage

// File: rtl/soc_eeg_streamer_fifo.sv
// sample_fifo: small circular sample buffer with flush and occupancy count.
module sample_fifo
    import soc_eeg_streamer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  AdcData_t                 din,
    output AdcData_t                 dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    AdcData_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the slot, so a push is legal even when full.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/soc_eeg_streamer.sv
// Streams one epoch of ADC samples into the CIM and waits for inference.
// Optional inference watchdog: define SOC_INFERENCE_TIMEOUT_EN.
module soc_eeg_streamer
    import soc_eeg_streamer_pkg::*;
#(
    parameter int SAMPLES_PER_EPOCH = 3000,
    parameter int FIFO_DEPTH        = 4,
    parameter int SAMPLE_GAP        = 2,
    parameter int TIMEOUT_CYCLES    = 1000000
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     start,
    input  logic     adc_valid,
    output logic     adc_ready,
    input  AdcData_t adc_data,
    output logic     cim_rst_n,
    output logic     cim_start_eeg_load,
    output logic     cim_new_eeg_data,
    output AdcData_t cim_eeg,
    output logic     cim_new_sleep_epoch,
    input  logic     cim_inference_complete,
    output logic     busy,
    output logic     epoch_done,
    output logic     timeout
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(SAMPLES_PER_EPOCH + 1);
    localparam int GW = $clog2(SAMPLE_GAP + 1);

    state_t          state;
    state_t          ns;
    logic [LW-1:0]   level;
    logic [SW-1:0]   sent;
    logic [SW-1:0]   sent_next;
    logic [GW-1:0]   gap;
    logic            rst_seen;
    logic            push;
    logic            pop;
    logic            flush;
    logic            sent_all;
    logic            full_next;
    logic            ready_next;
    logic            inf_timeout;
    logic            fifo_full;
    logic            fifo_empty;
    AdcData_t        fifo_dout;

    assign push      = adc_valid && adc_ready;
    assign flush     = (state == IDLE) && start;
    assign sent_all  = (sent == SW'(SAMPLES_PER_EPOCH));
    assign pop       = (state == STREAM) && !fifo_empty && (gap == '0) && !sent_all;
    assign sent_next = sent + SW'(pop);
    assign full_next = !flush && ((fifo_full && !pop) ||
                       (level == LW'(FIFO_DEPTH - 1) && push && !pop));
    assign ready_next = (ns == LOAD_START ||
                        (ns == STREAM && sent_next != SW'(SAMPLES_PER_EPOCH))) && !full_next;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   (adc_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (level)
    );

`ifdef SOC_INFERENCE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wait_cnt <= '0;
        else if (state != WAIT_INF) wait_cnt <= '0;
        else wait_cnt <= wait_cnt + TW'(1);
    end

    assign inf_timeout = (state == WAIT_INF) && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    // Watchdog compiled out: never fires.
    assign inf_timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= ns;
    end

    always_comb begin
        ns = state;
        unique case (state)
            IDLE:       if (start) ns = LOAD_START;
            LOAD_START: ns = STREAM;
            STREAM:     if (sent_all) ns = EPOCH;
            EPOCH:      ns = WAIT_INF;
            WAIT_INF: begin
                if (cim_inference_complete) ns = DONE;
                else if (inf_timeout) ns = IDLE;
            end
            DONE:       ns = IDLE;
            default:    ns = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sent                <= '0;
            gap                 <= '0;
            rst_seen            <= 1'b0;
            cim_rst_n           <= 1'b0;
            adc_ready           <= 1'b0;
            cim_start_eeg_load  <= 1'b0;
            cim_new_eeg_data    <= 1'b0;
            cim_eeg             <= '0;
            cim_new_sleep_epoch <= 1'b0;
            busy                <= 1'b0;
            epoch_done          <= 1'b0;
            timeout             <= 1'b0;
        end else begin
            // CIM leaves reset two cycles after the system does.
            rst_seen            <= 1'b1;
            cim_rst_n           <= rst_seen;
            adc_ready           <= ready_next;
            cim_start_eeg_load  <= (ns == LOAD_START);
            cim_new_eeg_data    <= pop;
            cim_new_sleep_epoch <= (ns == EPOCH);
            busy                <= (ns != IDLE);
            epoch_done          <= (ns == DONE);
            if (pop) cim_eeg <= fifo_dout;
            if (inf_timeout && !cim_inference_complete) timeout <= 1'b1;
            if (flush) begin
                sent <= '0;
                gap  <= '0;
            end else begin
                sent <= sent_next;
                if (pop) gap <= GW'(SAMPLE_GAP - 1);
                else if (gap != '0) gap <= gap - GW'(1);
            end
        end
    end

endmodule

// File: tb/tb_soc_eeg_streamer.sv
// Self-checking bench for soc_eeg_streamer.
// Directed and randomized epochs.
module tb_soc_eeg_streamer;
  import soc_eeg_streamer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;

  logic a_start = 0, a_valid = 0, a_cmp = 0;
  logic a_ready, a_rst_n, a_load, a_new;
  logic a_sleep, a_busy, a_done, a_to;
  AdcData_t a_data = '0, a_eeg;

  logic b_start = 0, b_valid = 0, b_cmp = 0;
  logic b_ready, b_rst_n, b_load, b_new;
  logic b_sleep, b_busy, b_done, b_to;
  AdcData_t b_data = '0, b_eeg;

  soc_eeg_streamer #(
    .SAMPLES_PER_EPOCH (4),
    .FIFO_DEPTH        (4),
    .SAMPLE_GAP        (2),
    .TIMEOUT_CYCLES    (10)
  ) u_a (
    .clk                    (clk),
    .rst                    (rst),
    .start                  (a_start),
    .adc_valid              (a_valid),
    .adc_ready              (a_ready),
    .adc_data               (a_data),
    .cim_rst_n              (a_rst_n),
    .cim_start_eeg_load     (a_load),
    .cim_new_eeg_data       (a_new),
    .cim_eeg                (a_eeg),
    .cim_new_sleep_epoch    (a_sleep),
    .cim_inference_complete (a_cmp),
    .busy                   (a_busy),
    .epoch_done             (a_done),
    .timeout                (a_to)
  );

  soc_eeg_streamer #(
    .SAMPLES_PER_EPOCH (8),
    .FIFO_DEPTH        (4),
    .SAMPLE_GAP        (8),
    .TIMEOUT_CYCLES    (10)
  ) u_b (
    .clk                    (clk),
    .rst                    (rst),
    .start                  (b_start),
    .adc_valid              (b_valid),
    .adc_ready              (b_ready),
    .adc_data               (b_data),
    .cim_rst_n              (b_rst_n),
    .cim_start_eeg_load     (b_load),
    .cim_new_eeg_data       (b_new),
    .cim_eeg                (b_eeg),
    .cim_new_sleep_epoch    (b_sleep),
    .cim_inference_complete (b_cmp),
    .busy                   (b_busy),
    .epoch_done             (b_done),
    .timeout                (b_to)
  );

  AdcData_t a_acc[$], a_pul[$], b_acc[$], b_pul[$];
  int a_pcyc[$], b_pcyc[$];
  int a_nload = 0, a_nsleep = 0;
  int a_ndone = 0, a_sleep_cyc = 0;
  int b_nload = 0, b_nsleep = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_valid && a_ready) a_acc.push_back(a_data);
    if (a_new) begin
      a_pul.push_back(a_eeg);
      a_pcyc.push_back(cyc);
    end
    if (a_load) a_nload <= a_nload + 1;
    if (a_sleep) begin
      a_nsleep <= a_nsleep + 1;
      a_sleep_cyc <= cyc;
    end
    if (a_done) a_ndone <= a_ndone + 1;
    if (b_valid && b_ready) b_acc.push_back(b_data);
    if (b_new) begin
      b_pul.push_back(b_eeg);
      b_pcyc.push_back(cyc);
    end
    if (b_load) b_nload <= b_nload + 1;
    if (b_sleep) b_nsleep <= b_nsleep + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    if (obs !== exp) begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_sleep_a(input int n0,
                              input string tag);
    for (int k = 0; k < 200 && a_nsleep == n0; k++)
      step(1);
    chk(tag, 32'(a_nsleep), 32'(n0 + 1));
  endtask

  task automatic run_directed(input logic [15:0] b0);
    int pb, lb, n0, i;
    bit r;
    pb = a_pul.size(); lb = a_nload;
    n0 = a_nsleep; i = 0;
    a_start = 1; step(1); a_start = 0;
    for (int k = 0; k < 20 && i < 4; k++) begin
      a_valid = 1; a_data = b0 + 16'(i);
      r = a_ready;
      step(1);
      if (r) i++;
    end
    a_valid = 0;
    wait_sleep_a(n0, "dir_sleep");
    chk("dir_load_cnt", 32'(a_nload - lb), 32'(1));
    chk("dir_pulse_cnt", 32'(a_pul.size() - pb),
        32'(4));
    for (int j = 0; j < 4; j++) begin
      chk("dir_data",
          32'((pb + j < a_pul.size()) ?
              a_pul[pb + j] : 16'hxxxx),
          32'(b0 + 16'(j)));
    end
    for (int j = 1; j < 4; j++) begin
      chk("dir_gap",
          32'((pb + j < a_pcyc.size()) ?
              a_pcyc[pb + j] - a_pcyc[pb + j - 1]
              : -1),
          32'(2));
    end
    chk("dir_sleep_after",
        32'((pb + 3 < a_pcyc.size()) &&
            (a_sleep_cyc > a_pcyc[pb + 3])),
        32'(1));
    chk("dir_eeg_hold", 32'(a_eeg),
        32'(b0 + 16'd3));
    chk("wait_ready_low", 32'(a_ready), 32'(0));
    chk("wait_busy", 32'(a_busy), 32'(1));
  endtask

  task automatic finish_a(input int dly);
    int n0;
    n0 = a_ndone;
    if (dly > 0) step(dly);
    a_cmp = 1; step(1); a_cmp = 0;
    chk("done_pulse", 32'(a_done), 32'(1));
    step(1);
    chk("done_clear", 32'(a_done), 32'(0));
    chk("idle_busy", 32'(a_busy), 32'(0));
    chk("done_count", 32'(a_ndone - n0), 32'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int pb, ab, n0, i, pc, lb;
    bit r, drop;
    logic [7:0] ov;

    step(3);
    ov = {a_ready, a_busy, a_rst_n, a_load,
          a_new, a_sleep, a_done, a_to};
    ntests++;
    if (ov !== 8'h00) begin
      nfail++;
      $error("FAIL rst_outs_a: observed %0h", ov);
    end
    chk("rst_eeg_a", 32'(a_eeg), 32'(16'h0));
    chk("rst_outs_b",
        32'({b_ready, b_busy, b_rst_n, b_load,
             b_new, b_sleep, b_done, b_to}),
        32'(8'h00));
    chk("rst_eeg_b", 32'(b_eeg), 32'(16'h0));
    rst = 0;
    step(1);
    ntests++;
    if (a_rst_n !== 1'b0) begin
      nfail++;
      $error("FAIL cim_rst_n_c1: observed %0b",
             a_rst_n);
    end
    step(1);
    ntests++;
    if (a_rst_n !== 1'b1) begin
      nfail++;
      $error("FAIL cim_rst_n_c2: observed %0b",
             a_rst_n);
    end

    a_cmp = 1; step(1); a_cmp = 0; step(1);
    chk("idle_cmp_busy", 32'(a_busy), 32'(0));
    chk("idle_cmp_done", 32'(a_ndone), 32'(0));

    run_directed(16'h0011);
    lb = a_nload;
    a_start = 1; step(1); a_start = 0; step(1);
    chk("busy_start_load", 32'(a_nload - lb),
        32'(0));
    chk("busy_start_busy", 32'(a_busy), 32'(1));
    finish_a(int'($urandom_range(0, 3)));

    for (int e = 0; e < 3; e++) begin
      pb = a_pul.size(); ab = a_acc.size();
      n0 = a_nsleep;
      a_start = 1; step(1); a_start = 0;
      for (int k = 0; k < 300 && a_nsleep == n0;
           k++) begin
        a_valid = 1'($urandom_range(0, 1));
        a_data = 16'($urandom);
        step(1);
      end
      a_valid = 0;
      chk("rnd_sleep", 32'(a_nsleep), 32'(n0 + 1));
      chk("rnd_pulse_cnt", 32'(a_pul.size() - pb),
          32'(4));
      for (int j = 0; j < 4; j++) begin
        chk("rnd_data",
            32'((pb + j < a_pul.size()) ?
                a_pul[pb + j] : 16'hxxxx),
            32'((ab + j < a_acc.size()) ?
                a_acc[ab + j] : 16'hxxxx));
      end
      for (int j = 1; j < 4; j++) begin
        chk("rnd_gap_min",
            32'((pb + j < a_pcyc.size()) &&
                (a_pcyc[pb + j] -
                 a_pcyc[pb + j - 1] >= 2)),
            32'(1));
      end
      finish_a(int'($urandom_range(0, 3)));
    end

`ifdef SOC_INFERENCE_TIMEOUT_EN
    n0 = a_ndone;
    run_directed(16'h0041);
    step(9);
    chk("to_before", 32'(a_to), 32'(0));
    step(1);
    chk("to_set", 32'(a_to), 32'(1));
    chk("to_idle", 32'(a_busy), 32'(0));
    chk("to_no_done", 32'(a_ndone - n0), 32'(0));
    step(1);
    chk("to_sticky", 32'(a_to), 32'(1));
`else
    run_directed(16'h0041);
    step(30);
    chk("no_to_flag", 32'(a_to), 32'(0));
    chk("no_to_waiting", 32'(a_busy), 32'(1));
    finish_a(0);
`endif

    pb = a_pul.size(); i = 0;
    a_start = 1; step(1); a_start = 0;
    for (int k = 0; k < 40 &&
         !(a_new && a_pul.size() - pb == 1); k++) begin
      a_valid = 1; a_data = 16'h0031 + 16'(i);
      r = a_ready;
      step(1);
      if (r) i++;
    end
    chk("mid_second_pulse", 32'(a_new), 32'(1));
    rst = 1; #1;
    chk("mid_rst_outs",
        32'({a_ready, a_busy, a_rst_n, a_load,
             a_new, a_sleep, a_done, a_to}),
        32'(8'h00));
    chk("mid_rst_eeg", 32'(a_eeg), 32'(16'h0));
    pc = a_pul.size(); a_valid = 0;
    step(2);
    rst = 0;
    step(1);
    chk("mid_cim_rst_n_c1", 32'(a_rst_n), 32'(0));
    step(1);
    chk("mid_cim_rst_n_c2", 32'(a_rst_n), 32'(1));
    chk("mid_no_pulses", 32'(a_pul.size()), 32'(pc));
    chk("mid_busy", 32'(a_busy), 32'(0));
    run_directed(16'h0021);
    finish_a(1);

    pb = b_pul.size(); ab = b_acc.size();
    n0 = b_nsleep; drop = 0;
    b_start = 1; step(1); b_start = 0;
    for (int k = 0; k < 300 && b_nsleep == n0;
         k++) begin
      if (!drop && !b_ready && b_acc.size() > ab) begin
        drop = 1;
        chk("fill_level",
            32'((b_acc.size() - ab) -
                (b_pul.size() - pb)),
            32'(4));
      end
      b_valid = 1;
      b_data = 16'h0100 + 16'(b_acc.size() - ab);
      step(1);
    end
    b_valid = 0;
    chk("b_sleep", 32'(b_nsleep), 32'(n0 + 1));
    chk("b_ready_dropped", 32'(drop), 32'(1));
    chk("b_load_cnt", 32'(b_nload), 32'(1));
    chk("b_pulse_cnt", 32'(b_pul.size() - pb),
        32'(8));
    for (int j = 0; j < 8; j++) begin
      ntests++;
      if (pb + j >= b_pul.size()) begin
        nfail++;
        $error("FAIL b_data %0d: missing", j);
      end else if (b_pul[pb + j] !==
                   16'h0100 + 16'(j)) begin
        nfail++;
        $error("FAIL b_data %0d: observed %0h",
               j, b_pul[pb + j]);
      end
    end
    for (int j = 1; j < 8; j++) begin
      chk("b_gap_min",
          32'((pb + j < b_pcyc.size()) &&
              (b_pcyc[pb + j] -
               b_pcyc[pb + j - 1] >= 8)),
          32'(1));
    end
    b_cmp = 1; step(1); b_cmp = 0;
    chk("b_done", 32'(b_done), 32'(1));
    step(2);

    $display("[TB] %0d tests run, %0d failed",
             ntests, nfail);
    $finish;
  end

endmodule
